// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state encoding, parity
// modes, the default oversample rate and the 3-input majority vote used by the sampler.
package uart_rx_param_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_mode_t;

   localparam int OVERSAMPLE_RATE = 16;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_param_sampler.sv
// uart_rx_sampler: 2-flop synchroniser for the asynchronous rx pad plus a 3-deep
// majority voter over the synchronised line as captured on s_tick.
module uart_rx_sampler
   import uart_rx_param_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rx,
   input  logic s_tick,
   output logic rx_s,
   output logic voted
);

   logic       rx_meta_q, rx_meta_d;
   logic       rx_s_q, rx_s_d;
   logic [1:0] hist_q, hist_d;

   always_comb begin
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
      hist_d    = hist_q;
      if (s_tick) begin
         hist_d = {hist_q[0], rx_s_q};
      end
   end

   // Idle-high reset so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         hist_q    <= 2'b11;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         hist_q    <= hist_d;
      end
   end

   // On a tick, the sample being captured now joins the two previous ones in the vote.
   assign rx_s  = rx_s_q;
   assign voted = majority3(hist_q[1], hist_q[0], rx_s_q);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with false-start rejection, majority voting
// and framing/parity error pulses. Parity support is built only with UART_RX_PARITY_EN.
module uart_rx_param
   import uart_rx_param_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = OVERSAMPLE_RATE,
   parameter int STOP_BITS   = 1,
   parameter int PARITY_MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_en,
   input  logic                 rx,
   input  logic                 s_tick,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int S_W = $clog2(OVERSAMPLE);
   localparam int N_W = $clog2(DATA_BITS + 1);
   localparam logic [S_W-1:0] S_HALF    = S_W'(OVERSAMPLE / 2 - 1);
   localparam logic [S_W-1:0] S_FULL    = S_W'(OVERSAMPLE - 1);
   localparam logic [N_W-1:0] N_LAST    = N_W'(DATA_BITS - 1);
   localparam logic [N_W-1:0] STOP_LAST = N_W'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
   localparam parity_mode_t PAR_CFG    = parity_mode_t'(PARITY_MODE);
   localparam bit           HAS_PARITY = (PAR_CFG != PAR_NONE);
   localparam rx_state_t    AFTER_DATA = HAS_PARITY ? PARITY : STOP;
`else
   localparam rx_state_t    AFTER_DATA = STOP;
`endif

   rx_state_t            state_q, state_d;
   logic [S_W-1:0]       s_cnt_q, s_cnt_d;
   logic [N_W-1:0]       n_cnt_q, n_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 frame_flag_q, frame_flag_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 rx_s, voted;
   logic                 tick_half, tick_full, last_data, last_stop;

   uart_rx_sampler u_sampler (
      .clk    (clk),
      .rst    (rst),
      .rx     (rx),
      .s_tick (s_tick),
      .rx_s   (rx_s),
      .voted  (voted)
   );

   assign tick_half = s_tick && (s_cnt_q == S_HALF);
   assign tick_full = s_tick && (s_cnt_q == S_FULL);
   assign last_data = (n_cnt_q == N_LAST);
   assign last_stop = (n_cnt_q == STOP_LAST);

`ifdef UART_RX_PARITY_EN
   logic par_flag_q, par_flag_d;
   logic parity_err_q, parity_err_d;
   logic par_expect;

   assign par_expect = (^shift_q) ^ (PAR_CFG == PAR_ODD);

   always_ff @(posedge clk) begin
      if (rst) begin
         par_flag_q   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_flag_q   <= par_flag_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         s_cnt_q      <= '0;
         n_cnt_q      <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         frame_flag_q <= 1'b0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_cnt_q      <= s_cnt_d;
         n_cnt_q      <= n_cnt_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         frame_flag_q <= frame_flag_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (!rx_s && rx_en) state_d = START;
         START:  if (tick_half) state_d = voted ? IDLE : DATA;
         DATA:   if (tick_full && last_data) state_d = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
         PARITY: if (tick_full) state_d = STOP;
`endif
         STOP:   if (tick_full && last_stop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters restart at every sample point; in STOP n_cnt counts stop bits instead of data bits.
   always_comb begin
      s_cnt_d      = s_cnt_q;
      n_cnt_d      = n_cnt_q;
      shift_d      = shift_q;
      data_d       = data_q;
      frame_flag_d = frame_flag_q;
      valid_d      = 1'b0;
      frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_flag_d   = par_flag_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            s_cnt_d      = '0;
            n_cnt_d      = '0;
            frame_flag_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag_d   = 1'b0;
`endif
         end
         START: begin
            if (s_tick) s_cnt_d = tick_half ? '0 : s_cnt_q + 1'b1;
         end
         DATA: begin
            if (tick_full) begin
               shift_d = {voted, shift_q[DATA_BITS-1:1]};
               s_cnt_d = '0;
               n_cnt_d = last_data ? '0 : n_cnt_q + 1'b1;
            end else if (s_tick) begin
               s_cnt_d = s_cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick_full) begin
               s_cnt_d = '0;
               if (voted != par_expect) par_flag_d = 1'b1;
            end else if (s_tick) begin
               s_cnt_d = s_cnt_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (tick_full) begin
               s_cnt_d = '0;
               n_cnt_d = n_cnt_q + 1'b1;
               if (!voted) frame_flag_d = 1'b1;
               if (last_stop) begin
                  data_d       = shift_q;
                  valid_d      = 1'b1;
                  frame_err_d  = frame_flag_q | ~voted;
`ifdef UART_RX_PARITY_EN
                  parity_err_d = par_flag_q;
`endif
               end
            end else if (s_tick) begin
               s_cnt_d = s_cnt_q + 1'b1;
            end
         end
         default: begin
            s_cnt_d = '0;
            n_cnt_d = '0;
         end
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;

endmodule
